// File: rtl/snake_pkg.sv
// Shared types and constants for the snake direction controller:
// heading encoding, keyboard codes and the opposite-direction test.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_W = 8'h57;
    localparam logic [7:0] KEY_S = 8'h53;
    localparam logic [7:0] KEY_A = 8'h41;
    localparam logic [7:0] KEY_D = 8'h44;
    localparam logic [7:0] KEY_P = 8'h50;

    localparam int unsigned TIMER_W = 28;
    localparam int unsigned DEB_W   = 24;

    // Same axis (bit1) but different sense (bit0).
    function automatic logic is_opposite(dir_t a, dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/dir_debounce.sv
// One button bit: 2-flop synchroniser, counter debouncer and a registered
// rising-edge pulse of the clean level.
module dir_debounce
    import snake_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic             clean_dly_q, clean_dly_d;
    logic             rise_q, rise_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = din;
        sync2_d     = sync1_q;
        clean_d     = clean_q;
        cnt_d       = '0;
        clean_dly_d = clean_q;
        rise_d      = clean_q & ~clean_dly_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == DEB_LAST) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            clean_q     <= 1'b0;
            clean_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            clean_q     <= clean_d;
            clean_dly_q <= clean_dly_d;
            rise_q      <= rise_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounced buttons + keyboard merged into a
// checked turn FIFO, released one turn per step. Pause key: SNAKE_PAUSE_KEY_EN.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned STEP_CYCLES = 10_000_000,
    parameter int unsigned QDEPTH      = 4,
    parameter logic [1:0]  RESET_DIR   = 2'd3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              btn,
    input  logic                    kb_valid,
    input  logic [7:0]              kb_code,
    input  logic                    game_over,
    output logic [1:0]              dir,
    output logic                    step_tick,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    drop,
    output logic                    paused
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(QDEPTH);

    logic [3:0]         btn_rise;
    dir_t               fifo_q [QDEPTH];
    dir_t               fifo_d [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    dir_t               dir_q, dir_d;
    logic               step_tick_q, step_tick_d;
    logic               drop_q, drop_d;
    logic               paused_q, paused_d;

    dir_t kb_dir, req_dir, ref_dir;
    logic kb_dir_ok, req_valid, wrap, pop, push, full;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        dir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (btn[i]),
            .rise  (btn_rise[i])
        );
    end

`ifdef SNAKE_PAUSE_KEY_EN
    logic pause_key;
    assign pause_key = kb_valid && (kb_code == KEY_P);
`endif

    always_comb begin
        kb_dir_ok = 1'b1;
        kb_dir    = DIR_UP;
        case (kb_code)
            KEY_W:   kb_dir = DIR_UP;
            KEY_S:   kb_dir = DIR_DOWN;
            KEY_A:   kb_dir = DIR_LEFT;
            KEY_D:   kb_dir = DIR_RIGHT;
            default: kb_dir_ok = 1'b0;
        endcase

        // Button index equals its direction encoding; lower index wins.
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if (btn_rise[0])                 req_dir = DIR_UP;
        else if (btn_rise[1])            req_dir = DIR_DOWN;
        else if (btn_rise[2])            req_dir = DIR_LEFT;
        else if (btn_rise[3])            req_dir = DIR_RIGHT;
        else if (kb_valid && kb_dir_ok)  req_dir = kb_dir;
        else                             req_valid = 1'b0;

        full    = (count_q == CNT_FULL);
        ref_dir = (count_q != '0) ? fifo_q[wr_ptr_q - PTR_W'(1)] : dir_q;
        wrap    = !game_over && !paused_q && (timer_q == TIMER_LAST);
        pop     = wrap && (count_q != '0);

        push   = 1'b0;
        drop_d = 1'b0;
        if (!game_over && req_valid) begin
            if (paused_q || (req_dir == ref_dir) || is_opposite(req_dir, ref_dir)
                || (full && !pop)) begin
                drop_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end

        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = req_dir;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        dir_d       = pop ? fifo_q[rd_ptr_q] : dir_q;
        step_tick_d = wrap;

        if (game_over)     timer_d = '0;
        else if (paused_q) timer_d = timer_q;
        else if (wrap)     timer_d = '0;
        else               timer_d = timer_q + 1'b1;

        if (game_over) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

`ifdef SNAKE_PAUSE_KEY_EN
        paused_d = game_over ? 1'b0 : (paused_q ^ pause_key);
`else
        paused_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_q      <= '{default: DIR_UP};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            dir_q       <= dir_t'(RESET_DIR);
            step_tick_q <= 1'b0;
            drop_q      <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            dir_q       <= dir_d;
            step_tick_q <= step_tick_d;
            drop_q      <= drop_d;
            paused_q    <= paused_d;
        end
    end

    assign dir       = dir_q;
    assign step_tick = step_tick_q;
    assign q_count   = count_q;
    assign drop      = drop_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random stimulus, each
// cycle compared against a queue-based reference model.
module tb_snake_dir_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned STEP = 8;
    localparam int unsigned QD   = 4;
    localparam int unsigned MAXC = 4000;

    localparam logic [7:0] K_W = 8'h57;
    localparam logic [7:0] K_S = 8'h53;
    localparam logic [7:0] K_A = 8'h41;
    localparam logic [7:0] K_D = 8'h44;
    localparam logic [7:0] K_P = 8'h50;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       kb_valid;
    logic [7:0] kb_code;
    logic       game_over;
    logic [1:0] dir;
    logic       step_tick;
    logic [2:0] q_count;
    logic       drop;
    logic       paused;

    always #5 clk = ~clk;

    snake_dir_ctrl #(
        .DEB_CYCLES  (DEB),
        .STEP_CYCLES (STEP),
        .QDEPTH      (QD),
        .RESET_DIR   (2'd3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .kb_valid  (kb_valid),
        .kb_code   (kb_code),
        .game_over (game_over),
        .dir       (dir),
        .step_tick (step_tick),
        .q_count   (q_count),
        .drop      (drop),
        .paused    (paused)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: button history per edge, turn queue, step phase.
    bit raw_hist   [4][MAXC];
    bit clean_hist [4][MAXC];
    int mk;
    int m_dir;
    int m_q[$];
    int m_phase;
    bit m_paused;
    bit e_tick;
    bit e_drop;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit sync_at(int b, int k);
        return (k >= 2) ? raw_hist[b][k-2] : 1'b0;
    endfunction

    function automatic bit clean_at(int b, int k);
        return (k >= 0) ? clean_hist[b][k] : 1'b0;
    endfunction

    function automatic bit opposite(int a, int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) ||
               (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    function automatic void model_reset();
        mk       = 0;
        m_dir    = 3;
        m_q.delete();
        m_phase  = 0;
        m_paused = 1'b0;
        e_tick   = 1'b0;
        e_drop   = 1'b0;
    endfunction

    function automatic void model_step();
        int req;
        int refd;
        bit prev, flip, wrap, pop, push, pkey;
        bit rq [4];
        req  = -1;
        pkey = 1'b0;
        push = 1'b0;
        for (int b = 0; b < 4; b++) begin
            raw_hist[b][mk] = btn[b];
            prev = clean_at(b, mk - 1);
            // Clean level flips once DEB consecutive synchronised samples disagree.
            flip = 1'b1;
            for (int j = 0; j < int'(DEB); j++)
                if (sync_at(b, mk - j) == prev) flip = 1'b0;
            clean_hist[b][mk] = flip ? !prev : prev;
            rq[b] = clean_at(b, mk - 2) && !clean_at(b, mk - 3);
        end
        for (int b = 0; b < 4; b++)
            if (req < 0 && rq[b]) req = b;
        if (req < 0 && kb_valid) begin
            case (kb_code)
                K_W: req = 0;
                K_S: req = 1;
                K_A: req = 2;
                K_D: req = 3;
                default: ;
            endcase
        end
`ifdef SNAKE_PAUSE_KEY_EN
        pkey = kb_valid && (kb_code == K_P);
`endif
        wrap   = !game_over && !m_paused && (m_phase == int'(STEP) - 1);
        pop    = wrap && (m_q.size() > 0);
        refd   = (m_q.size() > 0) ? m_q[$] : m_dir;
        e_drop = 1'b0;
        if (!game_over && req >= 0) begin
            if (m_paused || req == refd || opposite(req, refd) ||
                (m_q.size() == int'(QD) && !pop))
                e_drop = 1'b1;
            else
                push = 1'b1;
        end
        e_tick = wrap;
        if (game_over) begin
            m_q.delete();
            m_phase  = 0;
            m_paused = 1'b0;
        end else begin
            if (!m_paused) m_phase = wrap ? 0 : m_phase + 1;
            if (pop) m_dir = m_q.pop_front();
            if (push) m_q.push_back(req);
            if (pkey) m_paused = !m_paused;
        end
        mk++;
    endfunction

    task automatic cycle(input logic [3:0] b, input logic kv, input logic [7:0] kc,
                         input logic go);
        btn       = b;
        kb_valid  = kv;
        kb_code   = kc;
        game_over = go;
        @(posedge clk);
        if (mk >= int'(MAXC) - 1) begin
            $display("FAIL model_range: got %0d expected below %0d", mk, MAXC);
            $fatal(1, "model history exhausted");
        end
        model_step();
        @(negedge clk);
        check("dir", int'(dir), m_dir);
        check("step_tick", int'(step_tick), int'(e_tick));
        check("q_count", int'(q_count), m_q.size());
        check("drop", int'(drop), int'(e_drop));
        check("paused", int'(paused), int'(m_paused));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic key(input logic [7:0] kc);
        cycle(4'b0000, 1'b1, kc, 1'b0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        btn       = '0;
        kb_valid  = 1'b0;
        kb_code   = '0;
        game_over = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dir", int'(dir), 3);
        check("rst_q_count", int'(q_count), 0);
        check("rst_step_tick", int'(step_tick), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_paused", int'(paused), 0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int go_left;
        logic [3:0] rb;
        logic [7:0] codes [6];

        reset     = 1'b0;
        btn       = '0;
        kb_valid  = 1'b0;
        kb_code   = '0;
        game_over = 1'b0;
        @(negedge clk);

        // Keyboard turn, released on the first step, then an opposite turn.
        do_reset();
        idle(2);
        key(K_W);
        check("kb_push_q_count", int'(q_count), 1);
        for (int i = 0; i < 20 && !step_tick; i++) idle(1);
        check("first_tick_seen", int'(step_tick), 1);
        check("first_tick_dir", int'(dir), 0);
        check("first_tick_q_count", int'(q_count), 0);
        key(K_S);
        check("opposite_drop", int'(drop), 1);
        check("opposite_q_count", int'(q_count), 0);

        // Short press, full press, bouncing press.
        do_reset();
        repeat (3) cycle(4'b0001, 1'b0, 8'h00, 1'b0);
        idle(12);
        check("short_press_dir", int'(dir), 3);
        repeat (6) cycle(4'b0001, 1'b0, 8'h00, 1'b0);
        idle(12);
        check("long_press_dir", int'(dir), 0);
        cycle(4'b0100, 1'b0, 8'h00, 1'b0);
        cycle(4'b0000, 1'b0, 8'h00, 1'b0);
        repeat (4) cycle(4'b0100, 1'b0, 8'h00, 1'b0);
        idle(16);
        check("bounce_press_dir", int'(dir), 2);
        check("bounce_press_q_count", int'(q_count), 0);

        // Fill the queue, overflow, then push coinciding with a step on a full queue.
        do_reset();
        key(K_W); key(K_A); key(K_W); key(K_A);
        check("full_q_count", int'(q_count), 4);
        key(K_W);
        check("overflow_drop", int'(drop), 1);
        check("overflow_q_count", int'(q_count), 4);
        idle(2);
        key(K_W);
        check("full_pushpop_tick", int'(step_tick), 1);
        check("full_pushpop_q_count", int'(q_count), 4);
        check("full_pushpop_dir", int'(dir), 0);
        check("full_pushpop_drop", int'(drop), 0);

        // Button edge and keyboard in the same cycle.
        do_reset();
        repeat (6) cycle(4'b0001, 1'b0, 8'h00, 1'b0);
        idle(1);
        key(K_A);
        check("arb_q_count", int'(q_count), 1);
        check("arb_drop", int'(drop), 0);

        // Game over flushes and freezes stepping.
        do_reset();
        key(K_W); key(K_A); key(K_W);
        check("pre_go_q_count", int'(q_count), 3);
        cycle(4'b0000, 1'b0, 8'h00, 1'b1);
        check("go_flush", int'(q_count), 0);
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0000, (i % 3) == 0, K_A, 1'b1);
            check("go_no_tick", int'(step_tick), 0);
            check("go_no_drop", int'(drop), 0);
        end
        check("go_dir", int'(dir), 3);
        idle(10);

`ifdef SNAKE_PAUSE_KEY_EN
        // Pause mid-count, request while paused, resume from the same count.
        do_reset();
        idle(3);
        key(K_P);
        check("pause_on", int'(paused), 1);
        idle(10);
        key(K_W);
        check("paused_drop", int'(drop), 1);
        key(K_P);
        check("pause_off", int'(paused), 0);
        idle(3);
        check("resume_no_tick", int'(step_tick), 0);
        idle(1);
        check("resume_tick", int'(step_tick), 1);
`endif

        // Random traffic with occasional game over and one mid-run reset.
        codes[0] = K_W; codes[1] = K_S; codes[2] = K_A;
        codes[3] = K_D; codes[4] = K_P; codes[5] = 8'h00;
        do_reset();
        go_left = 0;
        rb      = '0;
        for (int i = 0; i < 2400; i++) begin
            logic       kv, go;
            logic [7:0] kc;
            int         sel;
            if (i == 1200) begin
                do_reset();
                rb      = '0;
                go_left = 0;
            end
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
            kv  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 5);
            kc  = (sel == 5) ? 8'($urandom_range(0, 255)) : codes[sel];
            if (go_left > 0) begin
                go_left--;
            end else if ($urandom_range(0, 199) == 0) begin
                go_left = $urandom_range(1, 12);
            end
            go = (go_left > 0);
            cycle(rb, kv, kc, go);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Parametrised direction-input controller for the snake game; successor to the ad-hoc button/keyboard merge at the game top level.
- Debounces four raw buttons and merges them with decoded keyboard strobes into one request stream.
- Rejects illegal turns and buffers accepted turns in a small FIFO.
- Releases one turn per game step from an internal step timer. Output heading and step tick drive snake_model.

Parameters:
- DEB_CYCLES, 1_000_000: consecutive stable cycles before a debounced level changes (1..2^24-1).
- STEP_CYCLES, 10_000_000: clock cycles per game step (2..2^28-1).
- QDEPTH, 4: turn FIFO depth, power of two, 2..16.
- RESET_DIR, 2'd3: heading after reset (0 up, 1 down, 2 left, 3 right).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- btn  in  4  raw buttons {right,left,down,up}, asynchronous to clk, active-high.
- kb_valid  in  1  one-cycle strobe; kb_code is valid when high.
- kb_code  in  8  ASCII code: 8'h57 up, 8'h53 down, 8'h41 left, 8'h44 right; other codes are ignored.
- game_over  in  1  level; freezes stepping and flushes the queue.
- dir  out  2  current heading.
- step_tick  out  1  one-cycle pulse per game step.
- q_count  out  clog2(QDEPTH)+1  FIFO occupancy.
- drop  out  1  one-cycle pulse when a request is rejected.
- paused  out  1  pause state (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clk edge):
  - dir=RESET_DIR; step_tick=0; q_count=0; drop=0; paused=0.
  - Timer=0; debounced levels=0; debounce counters=0.
  - Reset mid-operation discards queued turns immediately.
- Input sync: each btn bit passes through a 2-flop synchroniser.
- Debounce, per bit:
  - Counter increments while the synchronised value differs from the clean level, and clears when they match.
  - When the counter reaches DEB_CYCLES-1, clean takes the synchronised value and the counter clears.
  - A rising edge of clean produces a request one cycle later.
- Request arbitration, at most one request per cycle:
  - Button edges win over kb_valid.
  - Among buttons: up > down > left > right.
  - Losers in the same cycle are discarded silently, with no drop pulse.
- Reference direction: FIFO tail entry if q_count>0, else dir.
- Opposite directions: equal bit1 and differing bit0.
- Request acceptance:
  - Rejected with drop=1 if it equals the reference or is opposite to it.
  - Rejected with drop=1 if the FIFO is full and no pop occurs this cycle.
  - Otherwise pushed.
  - Push and pop in the same cycle on a full FIFO: both occur, and q_count stays QDEPTH.
- Step timer:
  - Counts 0..STEP_CYCLES-1 and wraps.
  - On wrap, step_tick=1 for exactly that cycle.
  - If q_count>0 on that cycle, the head entry is popped and dir takes it on the same edge, so the new dir is visible together with step_tick.
  - An empty FIFO leaves dir unchanged.
- game_over==1:
  - Timer held at 0; step_tick=0.
  - FIFO flushed (q_count=0 next cycle); requests ignored with no drop pulse; dir held.
  - Stepping resumes from count 0 when game_over deasserts.
- Width rules:
  - FIFO pointers are clog2(QDEPTH) bits and wrap naturally.
  - q_count never exceeds QDEPTH or underflows.
- Latency:
  - Button press to request: DEB_CYCLES+3 cycles.
  - kb_valid to push: 1 cycle.
  - Push to effect on dir: next step_tick with the FIFO drained ahead.

Optional Feature:
- Macro: SNAKE_PAUSE_KEY_EN.
- Defined: kb_valid with kb_code==8'h50 ('P') toggles paused, and does not count as a direction request.
  - While paused: timer frozen at its current value, step_tick=0, direction requests dropped with drop=1, queue contents retained.
  - game_over forces paused=0.
- Undefined: paused is tied 0 and 8'h50 is ignored like any other unmapped code.

Decomposition:
- Shared package snake_pkg holds:
  - Direction typedef dir_t (2 bits) with constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - Key-code constants KEY_W, KEY_S, KEY_A, KEY_D, KEY_P.
  - Function is_opposite(dir_t a, dir_t b).
- One sub-module, dir_debounce: a 1-bit synchroniser, debouncer and rise detector, instantiated four times.
- FIFO and timer stay inline.

Test Plan:
- Reset with RESET_DIR=3, STEP_CYCLES=8, DEB_CYCLES=4 -> dir=3, q_count=0, step_tick first at cycle 8 after reset release, then every 8 cycles.
- kb_valid with kb_code=8'h57 at cycle 2 -> q_count=1; at the next tick dir=0 and q_count=0. Then 8'h53 -> drop pulse, q_count stays 0.
- btn[0] held 3 cycles then released -> no request. Held 6 cycles -> exactly one push. Bounce pattern 1,0,1,1,1,1 -> exactly one push.
- QDEPTH=4, five legal alternating keys (up, left, up, left, up) starting from dir=3 -> 4 pushes, 5th gives drop=1. A request coinciding with step_tick while full -> accepted, q_count stays 4.
- btn up rising edge and kb_valid 8'h41 in the same cycle -> only up queued, no drop pulse.
- game_over asserted with q_count=3 -> q_count=0 next cycle, no step_tick for 20 cycles, dir unchanged. With SNAKE_PAUSE_KEY_EN defined, 'P' freezes the timer mid-count, and a second 'P' resumes from the same count.
